// File: rtl/spi_rom_pkg.sv
// Shared constants and types for the SPI ROM read sequencer.
// Covers the READ command, the command+address frame length and the FSM states.
package spi_rom_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam int         CMD_ADDR_BITS = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_OUT,
        SHIFT_IN
    } state_e;

    // Total SCLK bits in a burst of nbytes data bytes.
    function automatic int unsigned burst_bits(input int unsigned nbytes);
        return CMD_ADDR_BITS + 8 * nbytes;
    endfunction

endpackage

// File: rtl/spi_rom_reader_if.sv
// Requester handshake plus SPI pin bundle for spi_rom_reader.
// The master side is the fetch logic together with the memory's MISO pin.
interface spi_rom_reader_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic [7:0]       data;
    logic             data_valid;
    logic             done;
    logic             spi_cs;
    logic             spi_sclk;
    logic             spi_mosi;
    logic             spi_miso;

    modport master (
        output start, addr, len, abort, spi_miso,
        input  busy, data, data_valid, done, spi_cs, spi_sclk, spi_mosi
    );

    modport slave (
        input  start, addr, len, abort, spi_miso,
        output busy, data, data_valid, done, spi_cs, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_rom_shifter.sv
// MSB-first parallel-load out-shifter for cmd+addr, plus the MISO in-shifter.
// byte_o is the byte that completes if the current MISO bit is shifted in now.
module spi_rom_shifter
    import spi_rom_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_i,
    input  logic [CMD_ADDR_BITS-1:0] load_val_i,
    input  logic                     shift_i,
    input  logic                     clr_i,
    input  logic                     miso_i,
    output logic                     mosi_o,
    output logic [7:0]               byte_o
);

    logic [CMD_ADDR_BITS-1:0] out_q;
    logic [6:0]               in_q;

    // Zeros shift in behind the frame, so MOSI idles low once cmd+addr is out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            in_q  <= '0;
        end else if (clr_i) begin
            out_q <= '0;
            in_q  <= '0;
        end else if (load_i) begin
            out_q <= load_val_i;
        end else if (shift_i) begin
            out_q <= {out_q[CMD_ADDR_BITS-2:0], 1'b0};
            in_q  <= {in_q[5:0], miso_i};
        end
    end

    assign mosi_o = out_q[CMD_ADDR_BITS-1];
    assign byte_o = {in_q, miso_i};

endmodule

// File: rtl/spi_rom_reader.sv
// SPI ROM read sequencer: sends READ + 24-bit address, then streams len bytes.
// SCLK runs at clk/2, mode 0; MISO is captured on the edge that ends SCLK high.
module spi_rom_reader
    import spi_rom_pkg::*;
#(
    parameter int         LEN_W    = 8,
    parameter logic [7:0] CMD_READ = spi_rom_pkg::CMD_READ
) (
    input logic             clk,
    input logic             reset,
    spi_rom_reader_if.slave bus
);

    localparam int CNT_W = $clog2(CMD_ADDR_BITS + 8 * (2 ** LEN_W - 1));

    state_e           state_q;
    logic             busy_q;
    logic             cs_q;
    logic             sclk_q;
    logic             dv_q;
    logic             done_q;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] bit_q;
    logic [CNT_W-1:0] last_q;

    logic       active;
    logic       accept;
    logic       shift;
    logic       clr;
    logic       mosi;
    logic [7:0] rx_byte;

    assign active = (state_q != IDLE);
    assign accept = (state_q == IDLE) && bus.start && (bus.len != '0);
    assign shift  = active && sclk_q && !bus.abort;
    assign clr    = active && bus.abort;

    spi_rom_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_val_i ({CMD_READ, bus.addr}),
        .shift_i    (shift),
        .clr_i      (clr),
        .miso_i     (bus.spi_miso),
        .mosi_o     (mosi),
        .byte_o     (rx_byte)
    );

    // bit_q indexes the current bit; last_q is the final bit index of the burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cs_q    <= 1'b0;
            sclk_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            bit_q   <= '0;
            last_q  <= '0;
        end else begin
            dv_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SHIFT_OUT;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        sclk_q  <= 1'b0;
                        bit_q   <= '0;
                        last_q  <= CNT_W'(burst_bits(32'(bus.len)) - 32'd1);
                    end else if (bus.start) begin
                        done_q <= 1'b1;
                    end
                end
                SHIFT_OUT, SHIFT_IN: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cs_q    <= 1'b0;
                        sclk_q  <= 1'b0;
                    end else if (!sclk_q) begin
                        sclk_q <= 1'b1;
                    end else begin
                        sclk_q <= 1'b0;
                        bit_q  <= bit_q + CNT_W'(1);
                        if (state_q == SHIFT_OUT && bit_q == CNT_W'(CMD_ADDR_BITS - 1))
                            state_q <= SHIFT_IN;
                        // Frame is a multiple of 8 bits, so bytes align on bit_q[2:0].
                        if (state_q == SHIFT_IN && bit_q[2:0] == 3'd7) begin
                            data_q <= rx_byte;
                            dv_q   <= 1'b1;
                        end
                        if (bit_q == last_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            cs_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.done       = done_q;
    assign bus.spi_cs     = cs_q;
    assign bus.spi_sclk   = sclk_q;
    assign bus.spi_mosi   = mosi;

endmodule

// File: tb/tb_spi_rom_reader.sv
// Cycle-accurate bench for spi_rom_reader against a timing-formula reference model.
// A byte queue stands in for the ROM and drives MISO bit by bit.
module tb_spi_rom_reader;
    import spi_rom_pkg::*;

    localparam int LEN_W = 8;

    logic       clk = 1'b0;
    logic       reset;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_data;
    logic [7:0] mem[$];

    spi_rom_reader_if #(.LEN_W(LEN_W)) bus();

    spi_rom_reader #(.LEN_W(LEN_W), .CMD_READ(8'h03)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {busy, cs, sclk, mosi, data_valid, done, data}
    function automatic logic [13:0] outs();
        return {bus.busy, bus.spi_cs, bus.spi_sclk, bus.spi_mosi,
                bus.data_valid, bus.done, bus.data};
    endfunction

    function automatic logic [13:0] idle_v();
        return {6'b0, exp_data};
    endfunction

    task automatic fill(input int l);
        mem.delete();
        for (int k = 0; k < l; k++) mem.push_back(8'($urandom));
    endtask

    // Called at a negedge; checks ncyc following cycles as idle.
    task automatic idle(input int ncyc, input logic try_abort);
        for (int i = 0; i < ncyc; i++) begin
            bus.start    = 1'b0;
            bus.abort    = try_abort;
            bus.spi_miso = 1'($urandom);
            @(negedge clk);
            chk("idle", 32'(outs()), 32'(idle_v()));
        end
        bus.abort = 1'b0;
    endtask

    // Called at a negedge: start is raised here and accepted at the next edge (E0).
    task automatic burst(input logic [23:0] a, input int l, input int abort_at,
                         input int ign_at, input int rst_at);
        logic [31:0] w;
        logic [13:0] e;
        logic        dv;
        logic        prev_sclk;
        int          last;
        int          b;
        int          rises;
        w         = {8'h03, a};
        last      = (l == 0) ? 1 : (abort_at > 0) ? abort_at + 1 : 65 + 16 * l;
        rises     = 0;
        prev_sclk = 1'b0;
        bus.start = 1'b1;
        bus.addr  = a;
        bus.len   = LEN_W'(l);
        bus.abort = 1'b0;
        for (int n = 1; n <= last; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                bus.start = 1'b0;
                bus.addr  = 24'($urandom);
                bus.len   = LEN_W'($urandom);
            end
            if (n == rst_at) begin
                #2 reset = 1'b1;
                #1 chk("rst_async", 32'(outs()), 32'h0);
                exp_data = 8'h00;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_hold", 32'(outs()), 32'h0);
                end
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            dv = 1'b0;
            b  = (n - 1) / 2;
            if (l == 0) begin
                e = {5'b0, 1'b1, exp_data};
            end else if (abort_at > 0 && n == last) begin
                e = idle_v();
            end else if (n == 65 + 16 * l) begin
                exp_data = mem[l-1];
                e = {4'b0, 2'b11, exp_data};
            end else begin
                if (n >= 81 && (n - 81) % 16 == 0) begin
                    exp_data = mem[(n-81)/16];
                    dv = 1'b1;
                end
                e = {1'b1, 1'b1, (n % 2 == 0), ((b < 32) ? w[31-b] : 1'b0),
                     dv, 1'b0, exp_data};
            end
            chk($sformatf("cyc%0d", n), 32'(outs()), 32'(e));
            if (bus.spi_sclk && !prev_sclk && bus.spi_cs) rises++;
            prev_sclk = bus.spi_sclk;
            bus.abort = (n == abort_at);
            bus.start = (n == ign_at);
            if (n == ign_at) begin
                bus.addr = ~a;
                bus.len  = LEN_W'(7);
            end
            if (b >= 32 && b < 32 + 8 * l)
                bus.spi_miso = mem[(b-32)/8][7-(b-32)%8];
            else
                bus.spi_miso = 1'($urandom);
        end
        bus.abort = 1'b0;
        bus.start = 1'b0;
        if (abort_at == 0 && l > 0 && rst_at == 0)
            chk("sclk_rises", 32'(rises), 32'(32 + 8 * l));
    endtask

    initial begin
        int l;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.addr     = '0;
        bus.len      = '0;
        bus.abort    = 1'b0;
        bus.spi_miso = 1'b0;
        exp_data     = 8'h00;
        #3 chk("reset", 32'(outs()), 32'h0);
        @(negedge clk);
        chk("reset_hold", 32'(outs()), 32'h0);
        reset = 1'b0;
        idle(2, 1'b0);

        mem = '{8'hA5};
        burst(24'h123456, 1, 0, 0, 0);
        idle(2, 1'b0);

        mem = '{8'h11, 8'h22, 8'h33};
        burst(24'hABCDEF, 3, 0, 0, 0);
        idle(1, 1'b0);

        // abort in the address phase, then restart in the very next cycle
        fill(2);
        burst(24'($urandom), 2, 20, 0, 0);
        fill(1);
        burst(24'($urandom), 1, 0, 0, 0);

        fill(1);
        burst(24'h00F00D, 1, 0, 30, 0);
        idle(1, 1'b0);

        burst(24'h000000, 0, 0, 0, 0);
        idle(4, 1'b0);
        idle(3, 1'b1);

        // abort during the data phase
        fill(3);
        burst(24'($urandom), 3, 66 + int'($urandom_range(0, 40)), 0, 0);
        idle(1, 1'b0);

        fill(2);
        burst(24'($urandom), 2, 0, 0, 70);
        fill(2);
        burst(24'($urandom), 2, 0, 0, 0);

        // back-to-back bursts with random addresses and lengths
        for (int i = 0; i < 4; i++) begin
            l = int'($urandom_range(1, 5));
            fill(l);
            burst(24'($urandom), l, 0, 0, 0);
        end
        idle(1, 1'b0);

        fill(255);
        burst(24'hFFFFFF, 255, 0, 0, 0);
        idle(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_rom_reader.md
# spi_rom_reader

Sequencer for the external SPI memory behind the VGA pixel path. It accepts a (start address, byte count) request and issues a standard READ command (0x03) followed by a 24-bit address. It then streams the requested bytes back one at a time with a valid strobe, and drives `spi_cs`/`spi_sclk`/`spi_mosi` and samples `spi_miso`. It sits between the display-timing/fetch logic (requester) and the chip pins. `spi_cs` is active high; the top level inverts it to make /CS.

## Interface
- `LEN_W`, default 8: width of the byte-count input; maximum burst is 2^LEN_W−1 bytes.
- `CMD_READ`, default 8'h03: command byte sent first.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `addr`  in  24  start byte address; captured on accept.
- `len`  in  LEN_W  byte count; captured on accept.
- `abort`  in  1  cancel the current transfer.
- `busy`  out  1  transfer in progress.
- `data`  out  8  last received byte, MSB first on the wire.
- `data_valid`  out  1  one-cycle strobe: `data` holds a new byte.
- `done`  out  1  one-cycle strobe: burst complete (not pulsed on abort).
- `spi_cs`  out  1  active-high chip select.
- `spi_sclk`  out  1  SPI clock, mode 0, idle low, clk/2.
- `spi_mosi`  out  1  command/address bits, MSB first.
- `spi_miso`  in  1  serial data from the memory.

## Operation
- States: IDLE, SHIFT_OUT (32 bits: cmd+addr), SHIFT_IN (8·len bits).
- Reset values: `busy`=0, `data`=0, `data_valid`=0, `done`=0, `spi_cs`=0, `spi_sclk`=0, `spi_mosi`=0, state IDLE.
- All outputs are registered.
- IDLE with `start`=1 and `len`≠0: capture `addr`/`len`, go to SHIFT_OUT, `busy`=1.
- IDLE with `start`=1 and `len`=0: no SPI activity; `done`=1 for one cycle; stay IDLE.
- `start` while `busy`=1 is ignored. `addr`/`len` changes after accept have no effect.
- Each bit takes 2 clk cycles: the low phase (`spi_sclk`=0, `spi_mosi` updated), then the high phase (`spi_sclk`=1).
- `spi_miso` is sampled at the clk edge that ends the high phase.
- `spi_mosi`=0 during SHIFT_IN and IDLE.
- Bit counter width covers 32+8·(2^LEN_W−1) bits.
- After each 8th SHIFT_IN bit: `data` is loaded and `data_valid` is pulsed.
- After the final bit: return to IDLE, `spi_cs`=0, `busy`=0, `done`=1. The final `data_valid` is pulsed in the same cycle.
- Abort while busy:
  - Next cycle is IDLE with `spi_cs`=0, `spi_sclk`=0, `busy`=0.
  - No `done` pulse; a partial byte is discarded.
  - `abort` has priority over `start` in the same cycle; `abort` in IDLE has no effect.
- Reset mid-transfer: immediate return to reset values; no strobes.

## Timing
- Accept edge is E0; cycle n is the cycle after edge En−1.
- Cycle 1: `spi_cs`=1, `spi_sclk`=0, `spi_mosi`=`CMD_READ`[7].
- Bit i occupies cycles 2i+1 (SCLK low) and 2i+2 (SCLK high).
- Bits 0–7: command. Bits 8–31: `addr`[23:0]. Bits 32…: data.
- Byte k (0-based): `data_valid`=1 in cycle 81+16k.
- Last byte's `data_valid` and `done` are in cycle 65+16·len, with `spi_cs`=0 in that cycle.
- Minimum CS-low gap between back-to-back bursts: 1 cycle (`start` accepted at the edge ending the `done` cycle).
- `len`=0: `done` in cycle 1.

## Structure
- Shared package `spi_rom_pkg`:
  - `CMD_READ` constant.
  - State enum {IDLE, SHIFT_OUT, SHIFT_IN}.
  - `CMD_ADDR_BITS`=32.
- Top holds the FSM, bit/byte counter and SCLK phase flop.
- One natural sub-module, `spi_rom_shifter`: 32-bit parallel-load MSB-first out-shifter plus 8-bit in-shifter, with shift-enable driven from the SCLK phase.

## Test plan
- **Single byte:** `start`, `addr`=0x123456, `len`=1, memory model returns 0xA5.
  - MOSI bits = 0x03,0x12,0x34,0x56.
  - `data`=0xA5 with `data_valid` and `done` in cycle 81; `spi_cs` low in cycle 81.
- **Burst:** `len`=3, model returns 0x11,0x22,0x33.
  - `data_valid` in cycles 81/97/113 with those values; `done` in cycle 113.
  - SCLK count per CS window = 56 rising edges.
- **Abort:** `abort` in cycle 20 (address phase).
  - Cycle 21: `spi_cs`=0, `busy`=0; no `done`/`data_valid`.
  - A new `start` is accepted the same cycle.
- **Ignored start:** `start` with different `addr` pulsed in cycle 30 of a `len`=1 transfer.
  - Original transfer unchanged; `done` in cycle 81 only.
- **Zero length:** `len`=0.
  - `done`=1 in cycle 1; `spi_cs`, `spi_sclk`, `busy` stay 0.
- **Reset mid-transfer:** assert `reset` asynchronously mid-cycle in cycle 70.
  - All outputs go to reset values immediately; no strobes follow.
  - After release, a fresh transfer runs with nominal timing.
